// File: rtl/dmem_dump_responder.sv
// Data-memory responder for the MEM stage: combinational reads, clocked writes,
// and a write-blocking 64-beat snapshot dump triggered by a rising edge on dump.
module dmem_dump_responder #(
    parameter int N      = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [N-1:0]      writeData,
    output logic [N-1:0]      readData,
    input  logic              dump,
    output logic              busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [N-1:0]      dump_data
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      mem_q [DEPTH];
    logic [N-1:0]      mem_d [DEPTH];
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              dump_q, dump_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N-1:0]      data_q, data_d;
    logic              req;

    assign req        = dump && !dump_q;
    assign busy       = (state_q == DUMP);
    assign readData   = memRead ? mem_q[address] : '0;
    assign dump_valid = valid_q;
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dump_d  = dump;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mem_d   = mem_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                valid_d = 1'b1;
                addr_d  = idx_q;
                data_d  = mem_q[idx_q];
                idx_d   = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes are held off for the whole capture window so the dump stays consistent.
        if (memWrite && !busy) begin
            mem_d[address] = writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dump_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dump_q  <= dump_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_dmem_dump_responder.sv
// Randomized scoreboard bench for dmem_dump_responder: a reference memory with
// snapshot-on-request model predicts reads, busy windows and every dump beat.
module tb_dmem_dump_responder;
  localparam int N = 64;
  localparam int ADDR_W = 6;
  localparam int CW = ADDR_W + N;

  logic              clk;
  logic              reset;
  logic              memWrite;
  logic              memRead;
  logic [ADDR_W-1:0] address;
  logic [N-1:0]      writeData;
  logic [N-1:0]      readData;
  logic              dump;
  logic              busy;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [N-1:0]      dump_data;

  dmem_dump_responder #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .memWrite(memWrite), .memRead(memRead),
    .address(address), .writeData(writeData), .readData(readData),
    .dump(dump), .busy(busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  logic [N-1:0]  model_mem [64];
  logic [CW-1:0] exp_q[$];
  int            cyc;
  int            pass_start;
  int            pass_end;
  logic          dump_prev;
  int            beats_seen;
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    exp_q.delete();
    pass_start = -1000;
    pass_end   = -1000;
    dump_prev  = 1'b0;
  endtask

  // A pass accepted at edge k captures memory as of edge k, blocks writes at
  // edges k+1..k+64 and accepts no new request until edge k+65.
  always @(posedge clk) begin
    if (!reset) begin
      bit blocked;
      cyc++;
      blocked = (cyc > pass_start) && (cyc <= pass_end);
      if (memWrite && !blocked) model_mem[address] = writeData;
      if (dump && !dump_prev && cyc > pass_end) begin
        pass_start = cyc;
        pass_end   = cyc + 64;
        for (int i = 0; i < 64; i++) exp_q.push_back({ADDR_W'(i), model_mem[i]});
      end
      dump_prev = dump;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      logic [CW-1:0] e;
      bit busy_exp;
      bit valid_exp;
      busy_exp  = (cyc >= pass_start) && (cyc < pass_end);
      valid_exp = (cyc > pass_start) && (cyc <= pass_end);
      check("busy", CW'(busy), CW'(busy_exp));
      check("dump_valid", CW'(dump_valid), CW'(valid_exp));
      check("readData", CW'(readData), CW'(memRead ? model_mem[address] : '0));
      if (dump_valid) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr %0d data %0h, required no beat", dump_addr, dump_data);
        end else begin
          e = exp_q.pop_front();
          check("beat", {dump_addr, dump_data}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input logic we, input logic re, input logic [ADDR_W-1:0] a,
                       input logic [N-1:0] d, input logic dmp);
    @(posedge clk);
    #1;
    memWrite  = we;
    memRead   = re;
    address   = a;
    writeData = d;
    dump      = dmp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int b0;
    int t;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    beats_seen = 0;
    model_reset();
    reset = 1'b1;
    memWrite = 1'b0;
    memRead = 1'b0;
    address = '0;
    writeData = '0;
    dump = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", CW'(busy), '0);
    check("rst_valid", CW'(dump_valid), '0);
    check("rst_addr", CW'(dump_addr), '0);
    check("rst_data", CW'(dump_data), '0);
    reset = 1'b0;

    // read after reset
    drive(1'b0, 1'b1, 6'd5, '0, 1'b0);
    @(negedge clk);
    check("read5_after_reset", CW'(readData), '0);
    drive(1'b0, 1'b0, 6'd5, '0, 1'b0);
    @(negedge clk);
    check("read_disabled", CW'(readData), '0);

    // same-cycle read/write shows old word, new word next cycle
    drive(1'b1, 1'b1, 6'd7, 64'hDEAD_BEEF_0000_0001, 1'b0);
    @(negedge clk);
    check("rw_same_cycle_old", CW'(readData), '0);
    drive(1'b0, 1'b1, 6'd7, '0, 1'b0);
    @(negedge clk);
    check("read7_new", CW'(readData), CW'(64'hDEAD_BEEF_0000_0001));

    // preload and single-pulse dump with a blocked write to address 40
    for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, ADDR_W'(i), N'(i + 'h100), 1'b0);
    b0 = beats_seen;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    idle(5);
    drive(1'b1, 1'b0, 6'd40, 64'hFFFF, 1'b0);
    idle(70);
    check("pulse_pass_beats", CW'(beats_seen - b0), CW'(64));
    drive(1'b0, 1'b1, 6'd40, '0, 1'b0);
    @(negedge clk);
    check("mem40_unchanged", CW'(readData), CW'(64'h128));

    // level-held dump gives one pass; a one-cycle low gives another
    b0 = beats_seen;
    for (int i = 0; i < 200; i++) drive(1'b0, 1'b0, '0, '0, 1'b1);
    check("held_one_pass", CW'(beats_seen - b0), CW'(64));
    b0 = beats_seen;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    idle(70);
    check("second_pass", CW'(beats_seen - b0), CW'(64));

    // randomized traffic with random dump toggling
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 2) == 0), $urandom_range(0, 1),
            ADDR_W'($urandom_range(0, 63)), {$urandom, $urandom},
            ($urandom_range(0, 39) == 0) ? ~dump : dump);
    end
    idle(70);

    // reset in the middle of a dump
    drive(1'b1, 1'b0, 6'd3, 64'h55, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    b0 = beats_seen;
    t = 0;
    while (t < 100 && (beats_seen - b0) < 21) begin
      @(negedge clk);
      t++;
    end
    check("reached_beat20", CW'((beats_seen - b0) >= 21), CW'(1));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_valid", CW'(dump_valid), '0);
    check("midrst_busy", CW'(busy), '0);
    check("midrst_addr", CW'(dump_addr), '0);
    check("midrst_data", CW'(dump_data), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    b0 = beats_seen;
    for (int i = 0; i < 80; i++) drive(1'b0, 1'b1, ADDR_W'($urandom_range(0, 63)), '0, 1'b0);
    drive(1'b0, 1'b1, 6'd3, '0, 1'b0);
    @(negedge clk);
    check("mem3_cleared", CW'(readData), '0);
    check("no_beats_after_reset", CW'(beats_seen - b0), '0);
    idle(3);

    check("queue_empty", CW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
